// File: rtl/mac_scaler.sv
// mac_scaler: two-pass 24x16 multiply through a 16x16 MAC, recombining the partial products into 40 bits
module mac_scaler #(
   parameter int MAC_LATENCY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_a,
   input  logic [15:0] in_k,
   output logic [15:0] mac_a,
   output logic [15:0] mac_b,
   input  logic [31:0] mac_o,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [39:0] out_p,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  a_hi_q, a_hi_d;
   logic [15:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
   logic [31:0] lo_q, lo_d;
   logic [39:0] out_p_q, out_p_d;
   logic        out_valid_q, out_valid_d;
   logic        cnt_hit;
   assign cnt_hit   = cnt_q == 2'(MAC_LATENCY);
   assign in_ready  = (state_q == IDLE) & ~reset;
   assign busy      = state_q != IDLE;
   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign out_p     = out_p_q;
   assign out_valid = out_valid_q;
   // Sequencer: low slice first, then high slice, waiting MAC_LATENCY cycles for each product
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_hi_d      = a_hi_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      lo_d        = lo_q;
      out_p_d     = out_p_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_hi_d  = in_a[23:16];
            mac_a_d = in_a[15:0];
            mac_b_d = in_k;
            cnt_d   = '0;
            state_d = LO;
         end
         LO: if (cnt_hit) begin
            lo_d    = mac_o;
            mac_a_d = {8'h00, a_hi_q};
            cnt_d   = '0;
            state_d = HI;
         end else cnt_d = cnt_q + 2'd1;
         HI: if (cnt_hit) begin
            out_p_d     = {8'h00, lo_q} + {mac_o[23:0], 16'h0000};
            out_valid_d = 1'b1;
            mac_a_d     = '0;
            mac_b_d     = '0;
            cnt_d       = '0;
            state_d     = DONE;
         end else cnt_d = cnt_q + 2'd1;
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // State registers; reset discards any in-flight job immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_hi_q      <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         lo_q        <= '0;
         out_p_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_hi_q      <= a_hi_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         lo_q        <= lo_d;
         out_p_q     <= out_p_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_mac_scaler.sv
// tb_mac_scaler: checks mac_scaler at MAC latencies 0, 1 and 2 against a plain a*k product model
module tb_mac_scaler;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid [3];
   logic        out_ready [3];
   logic [23:0] in_a [3];
   logic [15:0] in_k [3];
   logic        in_ready [3];
   logic        out_valid [3];
   logic        busy [3];
   logic [15:0] mac_a [3];
   logic [15:0] mac_b [3];
   logic [31:0] mac_o [3];
   logic [39:0] out_p [3];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      logic [31:0] prod, p1, p2;
      assign prod = 32'(mac_a[g]) * 32'(mac_b[g]);
      always_ff @(posedge clk) begin
         p1 <= prod;
         p2 <= p1;
      end
      assign mac_o[g] = g == 0 ? prod : g == 1 ? p1 : p2;
      mac_scaler #(.MAC_LATENCY(g)) dut (
         .clk(clk), .reset(reset), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_a(in_a[g]), .in_k(in_k[g]), .mac_a(mac_a[g]), .mac_b(mac_b[g]), .mac_o(mac_o[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_p(out_p[g]), .busy(busy[g])
      );
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One job on DUT i: checks operand slices per cycle, result latency (cycles after accept cycle) and product
   task automatic run_job(input int i, input logic [23:0] a, input logic [15:0] k);
      int cyc;
      logic [15:0] exp_a;
      logic [39:0] exp_p;
      exp_p = 40'(a) * 40'(k);
      cyc = 0;
      while (!in_ready[i] && cyc < 50) begin tick(); cyc++; end
      tests++;
      if (in_ready[i] !== 1'b1) begin fails++; $display("FAIL job_ready dut%0d: in_ready=%b required 1", i, in_ready[i]); end
      in_a[i] = a; in_k[i] = k; in_valid[i] = 1'b1; out_ready[i] = 1'b1;
      tick();
      in_valid[i] = 1'b0; in_a[i] = 24'($urandom); in_k[i] = 16'($urandom);
      cyc = 1;
      while (!out_valid[i] && cyc < 20) begin
         exp_a = cyc <= i + 1 ? a[15:0] : {8'h00, a[23:16]};
         tests++;
         if (mac_a[i] !== exp_a || mac_b[i] !== k) begin
            fails++;
            $display("FAIL operands dut%0d cyc%0d: mac_a=%h mac_b=%h required %h %h", i, cyc, mac_a[i], mac_b[i], exp_a, k);
         end
         tick(); cyc++;
      end
      tests++;
      if (cyc != 2 * i + 3) begin fails++; $display("FAIL latency dut%0d: %0d cycles required %0d", i, cyc, 2 * i + 3); end
      tests++;
      if (out_p[i] !== exp_p) begin fails++; $display("FAIL product dut%0d a=%h k=%h: out_p=%h required %h", i, a, k, out_p[i], exp_p); end
      tests++;
      if (mac_a[i] !== 16'h0 || mac_b[i] !== 16'h0) begin fails++; $display("FAIL done_operands dut%0d: mac_a=%h mac_b=%h required 0 0", i, mac_a[i], mac_b[i]); end
      tick();
      tests++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
         fails++;
         $display("FAIL complete dut%0d: out_valid=%b in_ready=%b busy=%b required 0 1 0", i, out_valid[i], in_ready[i], busy[i]);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_a[i] = '0; in_k[i] = '0;
      end
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || mac_a[i] !== 16'h0 || mac_b[i] !== 16'h0 || out_p[i] !== 40'h0) begin
            fails++;
            $display("FAIL reset_state dut%0d: rdy=%b ov=%b busy=%b a=%h b=%h p=%h required all 0", i, in_ready[i], out_valid[i], busy[i], mac_a[i], mac_b[i], out_p[i]);
         end
      end
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready[i] !== 1'b1) begin fails++; $display("FAIL reset_release dut%0d: in_ready=%b required 1", i, in_ready[i]); end
      end
   endtask

   task automatic test_directed;
      run_job(0, 24'h000003, 16'h0005);
      run_job(2, 24'hFFFFFF, 16'hFFFF);
      run_job(1, 24'h000000, 16'hFFFF);
      run_job(1, 24'hFFFFFF, 16'h0000);
   endtask

   task automatic test_random_jobs;
      for (int n = 0; n < 6; n++)
         for (int i = 0; i < 3; i++) run_job(i, 24'($urandom), 16'($urandom));
   endtask

   task automatic test_backpressure;
      logic [23:0] a;
      logic [15:0] k;
      logic [39:0] exp_p;
      int cyc;
      a = 24'($urandom); k = 16'($urandom); exp_p = 40'(a) * 40'(k);
      in_a[0] = a; in_k[0] = k; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      cyc = 0;
      while (!out_valid[0] && cyc < 20) begin tick(); cyc++; end
      for (int n = 0; n < 20; n++) begin
         in_valid[0] = 1'($urandom); in_a[0] = 24'($urandom); in_k[0] = 16'($urandom);
         tick();
         tests++;
         if (out_valid[0] !== 1'b1 || out_p[0] !== exp_p || in_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL backpressure cyc%0d: ov=%b p=%h rdy=%b required 1 %h 0", n, out_valid[0], out_p[0], in_ready[0], exp_p);
         end
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      tick();
      tests++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: ov=%b rdy=%b busy=%b required 0 1 0", out_valid[0], in_ready[0], busy[0]);
      end
      repeat (4) tick();
      tests++;
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin fails++; $display("FAIL bp_ghost_job: busy=%b ov=%b required 0 0", busy[0], out_valid[0]); end
   endtask

   task automatic test_reset_mid_job;
      in_a[1] = 24'hABCDEF; in_k[1] = 16'h1234; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      tick(); tick();
      tests++;
      if (mac_a[1] !== 16'h00AB) begin fails++; $display("FAIL pre_reset_hi: mac_a=%h required 00ab", mac_a[1]); end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (mac_a[1] !== 16'h0 || mac_b[1] !== 16'h0 || out_p[1] !== 40'h0 || out_valid[1] !== 1'b0 || busy[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_job: a=%h b=%h p=%h ov=%b busy=%b rdy=%b required all 0", mac_a[1], mac_b[1], out_p[1], out_valid[1], busy[1], in_ready[1]);
      end
      tick();
      reset = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         tests++;
         if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin fails++; $display("FAIL post_reset cyc%0d: ov=%b busy=%b required 0 0", n, out_valid[1], busy[1]); end
      end
      run_job(1, 24'h123456, 16'h0100);
   endtask

   task automatic test_back_to_back;
      logic [39:0] q [$];
      logic [39:0] exp_p;
      int last_acc = -1;
      int n_acc = 0;
      int n_res = 0;
      logic rdy;
      in_a[1] = 24'($urandom); in_k[1] = 16'($urandom); in_valid[1] = 1'b1; out_ready[1] = 1'b1;
      for (int cyc = 0; cyc < 800 && n_res < 100; cyc++) begin
         rdy = in_ready[1];
         if (rdy) q.push_back(40'(in_a[1]) * 40'(in_k[1]));
         tick();
         if (rdy) begin
            if (last_acc >= 0) begin
               tests++;
               if (cyc - last_acc != 6) begin fails++; $display("FAIL b2b_spacing: %0d cycles required 6", cyc - last_acc); end
            end
            last_acc = cyc; n_acc++;
            in_a[1] = 24'($urandom); in_k[1] = 16'($urandom);
         end
         if (out_valid[1]) begin
            exp_p = q.size() > 0 ? q.pop_front() : 40'hX;
            tests++;
            if (out_p[1] !== exp_p) begin fails++; $display("FAIL b2b_product #%0d: out_p=%h required %h", n_res, out_p[1], exp_p); end
            n_res++;
         end
      end
      in_valid[1] = 1'b0;
      tests++;
      if (n_res != 100) begin fails++; $display("FAIL b2b_count: %0d results required 100", n_res); end
      repeat (10) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random_jobs();
      test_backpressure();
      test_reset_mid_job();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mac_scaler.md
# mac_scaler

Two-pass multiplier sequencer that feeds the iCE40 16x16 DSP multiplier and consumes its product. It accepts a 24-bit unsigned timestamp delta and a 16-bit unsigned scale coefficient over a valid/ready handshake. It issues the low and high operand slices to the MAC in turn and recombines the two partial products into a 40-bit result. It sits between the pulse-timing stage and the angle-conversion logic, and owns the only operand path into the MAC.

## Interface
Parameters:
- MAC_LATENCY, default 0 — cycles from operands on mac_a/mac_b to the matching product on mac_o. Legal values 0..2, matching the MAC's configured input and pipeline registers.

Ports:
- clk  in  1  — system clock; all state changes on the rising edge.
- reset  in  1  — asynchronous, active-high; clears all state.
- in_valid  in  1  — in_a/in_k are valid.
- in_ready  out  1  — block accepts a job; high only in IDLE.
- in_a  in  24  — unsigned multiplicand (timestamp delta).
- in_k  in  16  — unsigned coefficient.
- mac_a  out  16  — MAC A operand (registered).
- mac_b  out  16  — MAC B operand (registered).
- mac_o  in  32  — MAC unsigned 16x16 product.
- out_valid  out  1  — out_p holds a result.
- out_ready  in  1  — downstream accepts out_p.
- out_p  out  40  — in_a * in_k, exact.
- busy  out  1  — state is not IDLE.

## Operation
- States: IDLE, LO, HI, DONE. A wait counter runs 0..MAC_LATENCY.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch a_hi = in_a[23:16] zero-extended to 16 bits;
  - load mac_a = in_a[15:0], mac_b = in_k;
  - clear the counter; go to LO.
- LO: mac_a/mac_b stay stable. The counter increments each cycle. When counter == MAC_LATENCY:
  - register lo = mac_o;
  - load mac_a = a_hi (mac_b unchanged);
  - clear the counter; go to HI.
- HI: when counter == MAC_LATENCY:
  - out_p = {8'b0, lo} + ({16'b0, mac_o[23:0]} << 16), 40-bit add;
  - out_valid = 1; mac_a = mac_b = 0; go to DONE.
  - The upper 8 bits of mac_o are zero by construction and are ignored.
- DONE: out_p and out_valid hold until out_ready. On out_valid & out_ready: out_valid = 0; go to IDLE.
- mac_a/mac_b are 0 in IDLE and DONE.
- No accumulation. Each job is independent; no state carries over between jobs.
- in_a/in_k may change freely after the accepting edge. mac_a/mac_b are stable from LO entry to HI exit except for the single LO→HI update.

## Timing
- Reset values (asserted mid-job included, immediate):
  - state IDLE, counter 0, mac_a 0, mac_b 0, lo 0, out_p 0, out_valid 0, busy 0;
  - in_ready forced 0 while reset is high, 1 from the first cycle after release;
  - any in-flight job is discarded and no partial out_valid appears.
- Handshake accepted at edge T:
  - LO occupies cycles T+1 .. T+1+MAC_LATENCY;
  - HI occupies the next MAC_LATENCY+1 cycles;
  - out_valid rises at cycle T+2·MAC_LATENCY+3 (T+3 for latency 0).
- Throughput: one job per 2·MAC_LATENCY+4 cycles with out_ready tied high. No overlap between jobs.
- out_ready high on the first DONE cycle: out_valid is high for exactly one cycle; IDLE the next cycle.
- Back-pressure: out_ready low holds DONE indefinitely; in_ready stays 0 throughout.
- in_valid outside IDLE is ignored (in_ready=0). There is no simultaneous accept-and-complete path.
- Maximum result: (2^24−1)·(2^16−1) = 0xFF_FEFF_0001, which fits 40 bits with no overflow.

## Test plan
- MAC_LATENCY=0, in_a=0x000003, in_k=0x0005, accepted at cycle 10 → out_valid at cycle 13, out_p=0x0F; mac_a=0x0003 in LO, 0x0000 in HI.
- MAC_LATENCY=2, in_a=0xFFFFFF, in_k=0xFFFF → out_valid exactly 7 cycles after accept, out_p=0xFFFEFF0001; mac_a=0x00FF during HI.
- out_ready held low 20 cycles after a result → out_p/out_valid stable, in_ready=0, in_valid pulses ignored; release → one-cycle accept, IDLE next cycle.
- Reset pulsed during HI (latency 1) → all outputs 0 immediately, no out_valid; new job in_a=0x123456, in_k=0x0100 → out_p=0x12345600.
- Back-to-back jobs with in_valid and out_ready tied high, MAC_LATENCY=1 → accepts every 6 cycles; 100 random operand pairs match a reference product.
